// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit: direct-mapped target table with 2-bit
// counters on the fetch side, outcome/mispredict resolution and training on the execute side.
module branch_predict_unit #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 32,
  parameter int TAG_BITS = 8,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [6:0]        ex_opcode,
  input  logic [2:0]        ex_fun3,
  input  logic              ex_branch,
  input  logic              ex_zero,
  input  logic              ex_less_signed,
  input  logic              ex_less_unsigned,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              ex_taken,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              illegal_branch,
  output logic [CNT_W-1:0]  perf_branches,
  output logic [CNT_W-1:0]  perf_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [6:0]       OPC_JAL  = 7'b1101111;
  localparam logic [6:0]       OPC_JALR = 7'b1100111;
  localparam logic [XLEN-1:0]  PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic                valid_q [ENTRIES];
  logic                valid_d [ENTRIES];
  logic [1:0]          ctr_q   [ENTRIES];
  logic [1:0]          ctr_d   [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [TAG_BITS-1:0] tag_d   [ENTRIES];
  logic [XLEN-1:0]     tgt_q   [ENTRIES];
  logic [XLEN-1:0]     tgt_d   [ENTRIES];
  logic [CNT_W-1:0]    perf_br_q, perf_br_d;
  logic [CNT_W-1:0]    perf_mp_q, perf_mp_d;

  logic [IDX-1:0]      if_idx_s, ex_idx_s;
  logic [TAG_BITS-1:0] if_tag_s, ex_tag_s;
  logic                if_hit_s, ex_hit_s;
  logic                is_jal_s, is_jalr_s;
  logic                taken_s, illegal_s, cond_br_s;
  logic                count_s, train_s, mispredict_s;

  assign if_idx_s  = if_pc[IDX+1:2];
  assign if_tag_s  = if_pc[IDX+TAG_BITS+1:IDX+2];
  assign ex_idx_s  = ex_pc[IDX+1:2];
  assign ex_tag_s  = ex_pc[IDX+TAG_BITS+1:IDX+2];
  assign is_jal_s  = (ex_opcode == OPC_JAL);
  assign is_jalr_s = (ex_opcode == OPC_JALR);
  assign if_hit_s  = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
  assign ex_hit_s  = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);

  // Fetch-side prediction straight from the registered table (no write bypass).
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = if_pc + PC_STEP;
    if (if_hit_s && ctr_q[if_idx_s][1]) begin
      pred_taken  = 1'b1;
      pred_target = tgt_q[if_idx_s];
    end else begin
      pred_taken  = 1'b0;
      pred_target = if_pc + PC_STEP;
    end
  end

  // Execute-side outcome decode; jumps take precedence over the branch flag.
  always_comb begin
    taken_s   = 1'b0;
    illegal_s = 1'b0;
    cond_br_s = 1'b0;
    if (ex_valid) begin
      if (is_jal_s || is_jalr_s) begin
        taken_s = 1'b1;
      end else if (ex_branch) begin
        cond_br_s = 1'b1;
        case (ex_fun3)
          3'b000:         taken_s = ex_zero;
          3'b001:         taken_s = !ex_zero;
          3'b100:         taken_s = ex_less_signed;
          3'b101:         taken_s = !ex_less_signed;
          3'b110:         taken_s = ex_less_unsigned;
          3'b111:         taken_s = !ex_less_unsigned;
          3'b010, 3'b011: begin
            cond_br_s = 1'b0;
            illegal_s = 1'b1;
          end
          default: begin
            cond_br_s = 1'b0;
            illegal_s = 1'b1;
          end
        endcase
      end else begin
        taken_s = 1'b0;
      end
    end else begin
      taken_s = 1'b0;
    end
  end

  assign mispredict_s = ex_valid && ((taken_s != ex_pred_taken) ||
                                     (taken_s && (ex_pred_target != ex_target)));
  assign count_s = ex_valid && (is_jal_s || is_jalr_s || cond_br_s);
  // JALR targets are register-dependent, so only JAL and legal branches train.
  assign train_s = ex_valid && (is_jal_s || cond_br_s);

  // Resolution outputs, forced to zero while the execute slot is empty.
  always_comb begin
    ex_taken       = taken_s;
    illegal_branch = illegal_s;
    mispredict     = mispredict_s;
    redirect_pc    = {XLEN{1'b0}};
    if (ex_valid) begin
      redirect_pc = taken_s ? ex_target : (ex_pc + PC_STEP);
    end else begin
      redirect_pc = {XLEN{1'b0}};
    end
  end

  // Table training: update counters on a hit, allocate on a taken miss.
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (train_s) begin
      if (ex_hit_s) begin
        if (taken_s) begin
          ctr_d[ex_idx_s] = (ctr_q[ex_idx_s] == 2'b11) ? 2'b11 : ctr_q[ex_idx_s] + 2'b01;
          tgt_d[ex_idx_s] = ex_target;
        end else begin
          ctr_d[ex_idx_s] = (ctr_q[ex_idx_s] == 2'b00) ? 2'b00 : ctr_q[ex_idx_s] - 2'b01;
        end
      end else if (taken_s) begin
        valid_d[ex_idx_s] = 1'b1;
        tag_d[ex_idx_s]   = ex_tag_s;
        tgt_d[ex_idx_s]   = ex_target;
        ctr_d[ex_idx_s]   = 2'b10;
      end else begin
        valid_d[ex_idx_s] = valid_q[ex_idx_s];
      end
    end else begin
      valid_d[ex_idx_s] = valid_q[ex_idx_s];
    end
  end

  // Saturating performance counters.
  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (count_s && (perf_br_q != CNT_MAX)) begin
      perf_br_d = perf_br_q + CNT_ONE;
    end else begin
      perf_br_d = perf_br_q;
    end
    if (mispredict_s && (perf_mp_q != CNT_MAX)) begin
      perf_mp_d = perf_mp_q + CNT_ONE;
    end else begin
      perf_mp_d = perf_mp_q;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;

  // State registers; reset wins over any same-edge training.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
        tag_q[i]   <= {TAG_BITS{1'b0}};
        tgt_q[i]   <= {XLEN{1'b0}};
      end
      perf_br_q <= {CNT_W{1'b0}};
      perf_mp_q <= {CNT_W{1'b0}};
    end else begin
      valid_q   <= valid_d;
      ctr_q     <= ctr_d;
      tag_q     <= tag_d;
      tgt_q     <= tgt_d;
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit; a second instance with
// narrow perf counters covers counter saturation.
module tb_branch_predict_unit;

  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_ALU  = 7'b0110011;

  logic        clk, rst_n;
  logic [31:0] if_pc;
  logic        ex_valid, ex_branch, ex_zero, ex_less_signed, ex_less_unsigned, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_fun3;

  logic        pred_taken, ex_taken, mispredict, illegal_branch;
  logic [31:0] pred_target, redirect_pc, perf_branches, perf_mispredicts;

  logic        s_pred_taken, s_ex_taken, s_mispredict, s_illegal_branch;
  logic [31:0] s_pred_target, s_redirect_pc;
  logic [3:0]  s_perf_branches, s_perf_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_predict_unit u_dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_fun3(ex_fun3),
    .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_less_signed(ex_less_signed),
    .ex_less_unsigned(ex_less_unsigned), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_taken(ex_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .illegal_branch(illegal_branch),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  branch_predict_unit #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_fun3(ex_fun3),
    .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_less_signed(ex_less_signed),
    .ex_less_unsigned(ex_less_unsigned), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_taken(s_ex_taken), .mispredict(s_mispredict),
    .redirect_pc(s_redirect_pc), .illegal_branch(s_illegal_branch),
    .perf_branches(s_perf_branches), .perf_mispredicts(s_perf_mispredicts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_ex(input logic [6:0] opc, input logic [31:0] pc, input logic br,
                          input logic [2:0] f3, input logic z, input logic ls, input logic lu,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_opcode = opc; ex_pc = pc; ex_branch = br; ex_fun3 = f3;
    ex_zero = z; ex_less_signed = ls; ex_less_unsigned = lu;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_opcode = 7'd0; ex_pc = 32'd0; ex_branch = 1'b0; ex_fun3 = 3'd0;
    ex_zero = 1'b0; ex_less_signed = 1'b0; ex_less_unsigned = 1'b0;
    ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); if_pc = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL reset_pred_target: got %h want 00000104", pred_target); end
    checks++; if (perf_branches !== 32'd0) begin errors++; $display("FAIL reset_perf_br: got %0d want 0", perf_branches); end
    checks++; if (perf_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_perf_mp: got %0d want 0", perf_mispredicts); end
    drive_ex(OPC_JAL, 32'h100, 1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h44);
    ex_valid = 1'b0; #1;
    checks++; if ({ex_taken, mispredict, illegal_branch} !== 3'b000) begin errors++; $display("FAIL idle_flags: got %b want 000", {ex_taken, mispredict, illegal_branch}); end
    checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL idle_redirect: got %h want 00000000", redirect_pc); end
    idle();
  endtask

  task automatic test_train_basic();
    @(negedge clk); drive_ex(OPC_BR, 32'h100, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0); #1;
    checks++; if (ex_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", ex_taken); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL beq_mispredict: got %b want 1", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL beq_redirect: got %h want 00000080", redirect_pc); end
    @(posedge clk);
    @(negedge clk); idle(); if_pc = 32'h100; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred: got %b want 1", pred_taken); end
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL alloc_target: got %h want 00000080", pred_target); end
  endtask

  task automatic test_counter();
    // counter 2 -> 1: predicted taken, resolves not taken
    @(negedge clk); drive_ex(OPC_BR, 32'h100, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80); #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL nt_mispredict: got %b want 1", mispredict); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL nt_redirect: got %h want 00000104", redirect_pc); end
    @(posedge clk); @(negedge clk); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr1_pred: got %b want 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL ctr1_target: got %h want 00000104", pred_target); end
    drive_ex(OPC_BR, 32'h100, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0); #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL nt_ok_mispredict: got %b want 0", mispredict); end
    @(posedge clk); @(negedge clk); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr0_pred: got %b want 0", pred_taken); end
    drive_ex(OPC_BR, 32'h100, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
    @(posedge clk); @(negedge clk); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr0to1_pred: got %b want 0", pred_taken); end
    drive_ex(OPC_BR, 32'h100, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h90); #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL wrong_target_mispredict: got %b want 1", mispredict); end
    ex_pred_target = 32'h80; #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL right_target_mispredict: got %b want 0", mispredict); end
    @(posedge clk); @(negedge clk); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr2_pred: got %b want 1", pred_taken); end
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL ctr2_target: got %h want 00000080", pred_target); end
    checks++; if (perf_branches !== 32'd5) begin errors++; $display("FAIL ctr_perf_br: got %0d want 5", perf_branches); end
    checks++; if (perf_mispredicts !== 32'd3) begin errors++; $display("FAIL ctr_perf_mp: got %0d want 3", perf_mispredicts); end
  endtask

  task automatic test_funct3();
    logic       exp_t, exp_ill;
    logic [2:0] fl;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 8; k++) begin
        fl = 3'(k);
        @(negedge clk);
        drive_ex(OPC_BR, 32'h400, 1'b1, 3'(f), fl[0], fl[1], fl[2], 32'h480, 1'b0, 32'h0); #1;
        case (f)
          0: exp_t = fl[0];
          1: exp_t = !fl[0];
          4: exp_t = fl[1];
          5: exp_t = !fl[1];
          6: exp_t = fl[2];
          7: exp_t = !fl[2];
          default: exp_t = 1'b0;
        endcase
        exp_ill = (f == 2) || (f == 3);
        checks++; if (ex_taken !== exp_t) begin errors++; $display("FAIL f3_taken f3=%0d flags=%b: got %b want %b", f, fl, ex_taken, exp_t); end
        checks++; if (illegal_branch !== exp_ill) begin errors++; $display("FAIL f3_illegal f3=%0d flags=%b: got %b want %b", f, fl, illegal_branch, exp_ill); end
        checks++; if (redirect_pc !== (exp_t ? 32'h480 : 32'h404)) begin errors++; $display("FAIL f3_redirect f3=%0d flags=%b: got %h", f, fl, redirect_pc); end
        checks++; if (mispredict !== exp_t) begin errors++; $display("FAIL f3_mispredict f3=%0d flags=%b: got %b want %b", f, fl, mispredict, exp_t); end
        #1 idle();
      end
    end
    // illegal branch hitting a trained entry must leave it alone
    @(negedge clk); drive_ex(OPC_BR, 32'h100, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0); #1;
    checks++; if ({illegal_branch, ex_taken, mispredict} !== 3'b100) begin errors++; $display("FAIL illegal_flags: got %b want 100", {illegal_branch, ex_taken, mispredict}); end
    @(posedge clk); @(negedge clk); idle(); if_pc = 32'h100; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL illegal_no_train: got %b want 1", pred_taken); end
    checks++; if (perf_branches !== 32'd5) begin errors++; $display("FAIL illegal_perf_br: got %0d want 5", perf_branches); end
  endtask

  task automatic test_jumps();
    @(negedge clk); drive_ex(OPC_JALR, 32'h200, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h340, 1'b0, 32'h0); #1;
    checks++; if ({ex_taken, mispredict} !== 2'b11) begin errors++; $display("FAIL jalr_flags: got %b want 11", {ex_taken, mispredict}); end
    checks++; if (redirect_pc !== 32'h340) begin errors++; $display("FAIL jalr_redirect: got %h want 00000340", redirect_pc); end
    @(posedge clk); @(negedge clk); idle(); if_pc = 32'h200; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL jalr_no_train: got %b want 0", pred_taken); end
    if_pc = 32'h100; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jalr_no_evict: got %b want 1", pred_taken); end
    drive_ex(OPC_JAL, 32'h304, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 32'h500, 1'b0, 32'h0); #1;
    checks++; if ({ex_taken, illegal_branch, mispredict} !== 3'b101) begin errors++; $display("FAIL jal_flags: got %b want 101", {ex_taken, illegal_branch, mispredict}); end
    @(posedge clk); @(negedge clk); idle(); if_pc = 32'h304; #1;
    checks++; if ({pred_taken, pred_target} !== {1'b1, 32'h500}) begin errors++; $display("FAIL jal_trained: got %b/%h want 1/00000500", pred_taken, pred_target); end
    drive_ex(OPC_ALU, 32'h700, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 32'h999); #1;
    checks++; if ({ex_taken, mispredict} !== 2'b01) begin errors++; $display("FAIL alu_flags: got %b want 01", {ex_taken, mispredict}); end
    checks++; if (redirect_pc !== 32'h704) begin errors++; $display("FAIL alu_redirect: got %h want 00000704", redirect_pc); end
    @(posedge clk); @(negedge clk); idle(); #1;
    checks++; if (perf_branches !== 32'd7) begin errors++; $display("FAIL jump_perf_br: got %0d want 7", perf_branches); end
    checks++; if (perf_mispredicts !== 32'd6) begin errors++; $display("FAIL jump_perf_mp: got %0d want 6", perf_mispredicts); end
  endtask

  task automatic test_alias();
    drive_ex(OPC_BR, 32'h180, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0);
    @(posedge clk); @(negedge clk); idle(); if_pc = 32'h180; #1;
    checks++; if ({pred_taken, pred_target} !== {1'b1, 32'h40}) begin errors++; $display("FAIL alias_180_hit: got %b/%h want 1/00000040", pred_taken, pred_target); end
    if_pc = 32'h100; #1;
    checks++; if ({pred_taken, pred_target} !== {1'b0, 32'h104}) begin errors++; $display("FAIL alias_100_evicted: got %b/%h want 0/00000104", pred_taken, pred_target); end
    drive_ex(OPC_BR, 32'h100, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
    @(posedge clk); @(negedge clk); idle(); #1;
    checks++; if ({pred_taken, pred_target} !== {1'b1, 32'h80}) begin errors++; $display("FAIL alias_100_back: got %b/%h want 1/00000080", pred_taken, pred_target); end
    if_pc = 32'h180; #1;
    checks++; if ({pred_taken, pred_target} !== {1'b0, 32'h184}) begin errors++; $display("FAIL alias_180_evicted: got %b/%h want 0/00000184", pred_taken, pred_target); end
    checks++; if ({perf_branches, perf_mispredicts} !== {32'd9, 32'd8}) begin errors++; $display("FAIL alias_perf: got %0d/%0d want 9/8", perf_branches, perf_mispredicts); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive_ex(OPC_BR, 32'h104, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'h90, 1'b0, 32'h0);
    if_pc = 32'h304; #1;
    checks++; if ({pred_taken, pred_target} !== {1'b1, 32'h500}) begin errors++; $display("FAIL collide_old_entry: got %b/%h want 1/00000500", pred_taken, pred_target); end
    @(posedge clk); @(negedge clk);
    drive_ex(OPC_BR, 32'h104, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 32'h90, 1'b0, 32'h0);
    if_pc = 32'h104; #1;
    checks++; if ({pred_taken, pred_target} !== {1'b1, 32'h90}) begin errors++; $display("FAIL b2b_ctr2: got %b/%h want 1/00000090", pred_taken, pred_target); end
    @(posedge clk); @(negedge clk);
    drive_ex(OPC_BR, 32'h104, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'h90, 1'b0, 32'h0); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL b2b_ctr1: got %b want 0", pred_taken); end
    @(posedge clk); @(negedge clk); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL b2b_ctr2_again: got %b want 1", pred_taken); end
    if_pc = 32'h304; #1;
    checks++; if ({pred_taken, pred_target} !== {1'b0, 32'h308}) begin errors++; $display("FAIL b2b_304_evicted: got %b/%h want 0/00000308", pred_taken, pred_target); end
    checks++; if ({perf_branches, perf_mispredicts} !== {32'd12, 32'd10}) begin errors++; $display("FAIL b2b_perf: got %0d/%0d want 12/10", perf_branches, perf_mispredicts); end
  endtask

  task automatic test_reset_collision();
    @(negedge clk); drive_ex(OPC_BR, 32'h500, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1; idle(); if_pc = 32'h500; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_update_discarded: got %b want 0", pred_taken); end
    if_pc = 32'h104; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_table_cleared: got %b want 0", pred_taken); end
    checks++; if ({perf_branches, perf_mispredicts} !== 64'd0) begin errors++; $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_branches, perf_mispredicts); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); drive_ex(OPC_JALR, 32'h200, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h340, 1'b0, 32'h0);
    end
    @(negedge clk); idle(); #1;
    checks++; if ({perf_branches, perf_mispredicts} !== {32'd20, 32'd20}) begin errors++; $display("FAIL wide_perf: got %0d/%0d want 20/20", perf_branches, perf_mispredicts); end
    checks++; if (s_perf_branches !== 4'hF) begin errors++; $display("FAIL sat_perf_br: got %h want f", s_perf_branches); end
    checks++; if (s_perf_mispredicts !== 4'hF) begin errors++; $display("FAIL sat_perf_mp: got %h want f", s_perf_mispredicts); end
  endtask

  initial begin
    test_reset();
    test_train_basic();
    test_counter();
    test_funct3();
    test_jumps();
    test_alias();
    test_back_to_back();
    test_reset_collision();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch decision logic, for the pipelined core.
- Fetch side: a direct-mapped branch target table with 2-bit saturating counters gives a taken/target prediction for the fetch PC.
- Execute side: resolves the actual outcome of JAL/JALR/conditional branches from ALU flags and flags mispredictions with a redirect PC.
- Trains the table on resolution and keeps saturating performance counters.

Parameters:
XLEN, 32, data/address width
ENTRIES, 32, table entries; power of two, >= 2; IDX = log2(ENTRIES)
TAG_BITS, 8, tag width taken from PC above the index bits; IDX+TAG_BITS+2 <= XLEN
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
if_pc  in  XLEN  fetch-stage PC
pred_taken  out  1  prediction for if_pc
pred_target  out  XLEN  predicted next PC for if_pc
ex_valid  in  1  execute-stage instruction valid
ex_pc  in  XLEN  PC of execute-stage instruction
ex_opcode  in  7  opcode
ex_fun3  in  3  funct3
ex_branch  in  1  conditional-branch decode flag
ex_zero  in  1  ALU operands equal
ex_less_signed  in  1  rs1 < rs2, signed
ex_less_unsigned  in  1  rs1 < rs2, unsigned
ex_target  in  XLEN  computed jump/branch target
ex_pred_taken  in  1  prediction carried down the pipe
ex_pred_target  in  XLEN  predicted target carried down the pipe
ex_taken  out  1  actual outcome
mispredict  out  1  flush request
redirect_pc  out  XLEN  correct next PC
illegal_branch  out  1  ex_branch with funct3 010/011
perf_branches  out  CNT_W  resolved control-flow instructions
perf_mispredicts  out  CNT_W  mispredictions

Behaviour:
- Reset: synchronous on rising clk with rst_n=0.
  - All entries valid=0, counter=2'b01, tag/target=0; perf counters=0.
  - Any execute update on that edge is discarded.
  - Combinational outputs follow inputs and table state.
- Index/tag: idx = pc[IDX+1:2]; tag = pc[IDX+TAG_BITS+1:IDX+2].
- Prediction (combinational from registered table, 0-cycle latency):
  - hit = valid[idx] && tag match.
  - If hit && counter[1]: pred_taken=1, pred_target=stored target.
  - Otherwise: pred_taken=0, pred_target=if_pc+4 (mod 2^XLEN).
- Resolution (combinational, only meaningful when ex_valid=1; all outputs 0 when ex_valid=0):
  - JAL (1101111) and JALR (1100111): taken=1, regardless of ex_branch.
  - Else if ex_branch, by funct3:
    - 000 (beq): zero.
    - 001 (bne): !zero.
    - 100 (blt): less_signed.
    - 101 (bge): !less_signed.
    - 110 (bltu): less_unsigned.
    - 111 (bgeu): !less_unsigned.
    - 010/011: taken=0, illegal_branch=1.
  - Otherwise taken=0.
  - ex_taken = taken.
  - redirect_pc = taken ? ex_target : ex_pc+4.
  - mispredict = ex_valid && (taken != ex_pred_taken || (taken && ex_pred_target != ex_target)).
  - Non-control instructions predicted taken therefore mispredict with redirect_pc = ex_pc+4.
- Training (registered; applies on the rising edge when ex_valid=1, rst_n=1, and the instruction is JAL or a legal conditional branch):
  - JALR and illegal branches are never trained.
  - Hit: counter +1 if taken (saturate at 3), -1 if not taken (saturate at 0); target <= ex_target when taken.
  - Miss and taken: allocate (replace any occupant): valid=1, tag, target=ex_target, counter=2'b10.
  - Miss and not taken: no change.
- Read/write collision: a same-cycle fetch lookup of the entry being written sees the old contents; there is no bypass.
- Perf counters:
  - perf_branches increments on each edge with ex_valid and JAL/JALR/legal branch.
  - perf_mispredicts increments on each edge with mispredict=1.
  - Both saturate at all-ones and do not wrap.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104; perf counters 0.
- Resolve beq at ex_pc=0x100, zero=1, target=0x80, pred_taken=0 -> ex_taken=1, mispredict=1, redirect_pc=0x80; next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x80.
- Same beq: not taken twice (counter 2->1->0), then taken once -> predictions after each edge are 0, 0, 0; counter at 1; taken again -> predicts taken.
- Every funct3 with ex_branch=1 over all zero/less flag combinations matches the resolution rules; 010 -> illegal_branch=1, ex_taken=0, no training.
- JALR at 0x200, target 0x340, predicted not taken -> mispredict=1, redirect_pc=0x340, table entry at 0x200 unchanged; aliasing PCs 0x100 and 0x100+4*ENTRIES evict each other.
- Assert rst_n=0 on the same edge as a taken-branch update -> table stays empty and perf counters stay 0; a back-to-back fetch/update collision returns the old entry; perf_branches preloaded to all-ones stays saturated.
